// File: rtl/qns_mod2_mc.sv
// qns_mod2_mc: time-multiplexed error-feedback noise shaper,
// order 0/1/2, odd-level quantizer, overload state clear.
module qns_mod2_mc #(
  parameter int IN_W    = 19,
  parameter int OUT_W   = 3,
  parameter int CH      = 2,
  parameter int OVF_LIM = 8,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [CW-1:0]          in_ch,
  input  logic [1:0]             mode,
  input  logic signed [IN_W-1:0] in,
  output logic                   out_valid,
  output logic [CW-1:0]          out_ch,
  output logic signed [OUT_W-1:0] out,
  output logic signed [IN_W-1:0] out_scaled,
  output logic                   ovf
);
  localparam int YW   = IN_W + 4;
  localparam int SH   = IN_W - OUT_W - 2;
  localparam int VMAX = 2 ** (OUT_W - 1) - 1;
  localparam int CNW  = $clog2(OVF_LIM + 1);

  localparam logic signed [YW-1:0] Y_S =
    YW'(2 ** SH);
  localparam logic signed [YW-1:0] Y_QHI =
    YW'(2 ** (OUT_W - 2) - 1);
  localparam logic signed [YW-1:0] Y_QLO =
    YW'(-(2 ** (OUT_W - 2)));
  localparam logic signed [YW-1:0] Y_EMAX =
    YW'(2 ** IN_W - 1);
  localparam logic signed [YW-1:0] Y_EMIN =
    YW'(-(2 ** IN_W));
  localparam logic signed [OUT_W-1:0] V_P =
    OUT_W'(VMAX);
  localparam logic signed [OUT_W-1:0] V_N =
    OUT_W'(-VMAX);
  localparam logic [CNW-1:0] CNT_TOP =
    CNW'(OVF_LIM - 1);

  logic signed [IN_W-1:0] r_x;
  logic [CW-1:0]          r_ch;
  logic [1:0]             r_mode;
  logic                   r_acc;
  logic                   w_acc;

  logic signed [IN_W:0] r_e1 [CH];
  logic signed [IN_W:0] r_e2 [CH];
  logic [CNW-1:0]       r_cnt [CH];

  logic signed [YW-1:0]    w_x;
  logic signed [YW-1:0]    w_e1;
  logic signed [YW-1:0]    w_e2;
  logic signed [YW-1:0]    w_yy;
  logic signed [YW-1:0]    w_q;
  logic signed [YW-1:0]    w_vs;
  logic signed [YW-1:0]    w_e;
  logic signed [OUT_W-1:0] w_v;
  logic signed [IN_W:0]    w_es;
  logic                    w_sat;
  logic                    w_clr;

  logic                    r_p2_vld;
  logic [CW-1:0]           r_p2_ch;
  logic signed [OUT_W-1:0] r_p2_v;
  logic                    r_p2_ovf;

  assign w_acc = en & in_valid & (int'(in_ch) < CH);

  // stage 1: capture the sample and its accept flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_x    <= '0;
      r_ch   <= '0;
      r_mode <= '0;
      r_acc  <= 1'b0;
    end else begin
      r_x    <= in;
      r_ch   <= in_ch;
      r_mode <= mode;
      r_acc  <= w_acc;
    end
  end

  assign w_x  = YW'(r_x);
  assign w_e1 = YW'(r_e1[r_ch]);
  assign w_e2 = YW'(r_e2[r_ch]);

  // loop filter: order chosen per sample, 3 acts as 2
  always_comb begin
    w_yy = w_x;
    unique case (r_mode)
      2'd0:    w_yy = w_x;
      2'd1:    w_yy = w_x + w_e1;
      default: w_yy = w_x + (w_e1 <<< 1) - w_e2;
    endcase
  end

  assign w_q = w_yy >>> (SH + 1);

  // odd-level quantizer: 2*floor(yy/2S)+1, clamped
  always_comb begin
    w_v = {w_q[OUT_W-2:0], 1'b1};
    if (w_q > Y_QHI) begin
      w_v = V_P;
    end else if (w_q < Y_QLO) begin
      w_v = V_N;
    end
  end

  assign w_vs  = YW'(w_v) <<< SH;
  assign w_e   = w_yy - w_vs;
  assign w_sat = (w_e > Y_S) || (w_e < -Y_S);

  // error saturated into the state register range
  always_comb begin
    w_es = w_e[IN_W:0];
    if (w_e > Y_EMAX) begin
      w_es = {1'b0, {IN_W{1'b1}}};
    end else if (w_e < Y_EMIN) begin
      w_es = {1'b1, {IN_W{1'b0}}};
    end
  end

  assign w_clr = w_sat && (r_cnt[r_ch] == CNT_TOP);

  // per-channel error state and overload counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        r_e1[i]  <= '0;
        r_e2[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else if (r_acc) begin
      if (w_clr) begin
        r_e1[r_ch]  <= '0;
        r_e2[r_ch]  <= '0;
        r_cnt[r_ch] <= '0;
      end else begin
        r_e2[r_ch]  <= r_e1[r_ch];
        r_e1[r_ch]  <= w_es;
        r_cnt[r_ch] <= w_sat ? r_cnt[r_ch] + 1'b1 : '0;
      end
    end
  end

  // stage 2 result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_p2_vld <= 1'b0;
      r_p2_ch  <= '0;
      r_p2_v   <= '0;
      r_p2_ovf <= 1'b0;
    end else begin
      r_p2_vld <= r_acc;
      if (r_acc) begin
        r_p2_ch  <= r_ch;
        r_p2_v   <= w_v;
        r_p2_ovf <= w_clr;
      end
    end
  end

  // output register, holds value while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out        <= '0;
      out_scaled <= '0;
      ovf        <= 1'b0;
    end else begin
      out_valid <= r_p2_vld;
      if (r_p2_vld) begin
        out_ch     <= r_p2_ch;
        out        <= r_p2_v;
        out_scaled <= IN_W'(r_p2_v) <<< SH;
        ovf        <= r_p2_ovf;
      end
    end
  end

endmodule
